noc_flit_dispatcher: RTL and testbench

Parametrised SRAM-to-NoC injector for the MapReduce front end. It streams a block of words out of the input SRAM and wraps each word in a NoC flit. Whole packets (tail-delimited) are distributed round-robin across `NUM_MAPPERS` mapper ports. Each mapper has its own credit counter; the block stalls SRAM reads when the current destination has no credit. Start/done handshake to the top-level controller.

---
 rtl/noc_flit_dispatcher.sv | 178 +++++++++++++++++
 tb/tb_noc_flit_dispatcher.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_flit_dispatcher.sv
// Streams a block of SRAM words into NoC flits and spreads whole packets
// round-robin over the enabled mapper ports, throttled by per-mapper credits.
module noc_flit_dispatcher #(
  parameter int NUM_MAPPERS      = 4,
  parameter int MAPPER_PORT_BASE = 0,
  parameter int DATA_WIDTH       = 32,
  parameter int ADDR_WIDTH       = 10,
  parameter int DEST_BITS        = 4,
  parameter int VC_BITS          = 1,
  parameter int CREDIT_DEPTH     = 4,
  localparam int FW = 2 + DEST_BITS + VC_BITS + DATA_WIDTH,
  localparam int CW = $clog2(CREDIT_DEPTH + 1)
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               start_i,
  input  logic [ADDR_WIDTH:0]                num_words_i,
  input  logic [NUM_MAPPERS-1:0]             mapper_mask_i,
  output logic                               sram_rd_en_o,
  output logic [ADDR_WIDTH-1:0]              sram_addr_o,
  input  logic [DATA_WIDTH-1:0]              sram_data_i,
  input  logic                               sram_tail_i,
  output logic [FW-1:0]                      flit_out_o,
  input  logic [NUM_MAPPERS*(VC_BITS+1)-1:0] credit_in_i,
  output logic [NUM_MAPPERS-1:0]             en_get_credit_o,
  output logic                               busy_o,
  output logic                               done_o,
  output logic                               credit_overflow_o
);

  localparam int CRW  = VC_BITS + 1;
  localparam int CURW = (NUM_MAPPERS > 1) ? $clog2(NUM_MAPPERS) : 1;
  localparam logic [CW-1:0] CreditFull = CW'(CREDIT_DEPTH);

  typedef enum logic [2:0] {IDLE, RD, CAP, SEND, FIN} state_e;

  state_e                            state_q, state_d;
  logic [ADDR_WIDTH-1:0]             addr_q, addr_d;
  logic [ADDR_WIDTH:0]               numWords_q, numWords_d;
  logic [NUM_MAPPERS-1:0]            mask_q, mask_d;
  logic [CURW-1:0]                   cur_q, cur_d;
  logic [DATA_WIDTH-1:0]             holdData_q, holdData_d;
  logic                              holdTail_q, holdTail_d;
  logic [FW-1:0]                     flit_q, flit_d;
  logic                              busy_q, busy_d;
  logic                              done_q, done_d;
  logic                              overflow_q;
  logic [NUM_MAPPERS-1:0][CW-1:0]    credit_q, credit_d;
  logic [NUM_MAPPERS-1:0]            consume;
  logic [NUM_MAPPERS-1:0]            overflowHit;
  logic                              sendFire;
  logic                              lastWord;
  logic                              unusedVcBits;

  function automatic logic [CURW-1:0] lowestEnabled(input logic [NUM_MAPPERS-1:0] mask);
    logic [CURW-1:0] pick;
    pick = '0;
    for (int i = NUM_MAPPERS - 1; i >= 0; i--) begin
      if (mask[CURW'(i)]) pick = CURW'(i);
    end
    return pick;
  endfunction

  // Closest enabled mapper above cur, wrapping; cur itself is the last resort.
  function automatic logic [CURW-1:0] nextEnabled(input logic [NUM_MAPPERS-1:0] mask,
                                                  input logic [CURW-1:0]        cur);
    logic [CURW-1:0] pick;
    int              cand;
    pick = cur;
    for (int k = NUM_MAPPERS; k >= 1; k--) begin
      cand = (int'(cur) + k) % NUM_MAPPERS;
      if (mask[CURW'(cand)]) pick = CURW'(cand);
    end
    return pick;
  endfunction

  assign sendFire = (state_q == SEND) && (credit_q[cur_q] != '0);
  assign lastWord = ({1'b0, addr_q} == (numWords_q - (ADDR_WIDTH + 1)'(1)));
  assign consume  = sendFire ? (NUM_MAPPERS'(1) << cur_q) : '0;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    numWords_d = numWords_q;
    mask_d     = mask_q;
    cur_d      = cur_q;
    holdData_d = holdData_q;
    holdTail_d = holdTail_q;
    flit_d     = '0;
    busy_d     = busy_q;
    done_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          numWords_d = num_words_i;
          mask_d     = mapper_mask_i;
          addr_d     = '0;
          cur_d      = lowestEnabled(mapper_mask_i);
          busy_d     = 1'b1;
          state_d    = (num_words_i == '0) ? FIN : RD;
        end
      end
      RD: state_d = CAP;
      CAP: begin
        holdData_d = sram_data_i;
        holdTail_d = sram_tail_i;
        state_d    = SEND;
      end
      SEND: begin
        if (sendFire) begin
          flit_d = {1'b1, holdTail_q, DEST_BITS'(MAPPER_PORT_BASE + int'(cur_q)),
                    {VC_BITS{1'b0}}, holdData_q};
          addr_d = addr_q + ADDR_WIDTH'(1);
          if (holdTail_q) cur_d = nextEnabled(mask_q, cur_q);
          state_d = lastWord ? FIN : RD;
        end
      end
      FIN: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A return and a consume on the same mapper cancel; a lone return at full saturates.
  for (genvar g = 0; g < NUM_MAPPERS; g++) begin : gCredit
    logic ret;
    logic atFull;
    assign ret            = credit_in_i[(g+1)*CRW-1];
    assign atFull         = (credit_q[g] == CreditFull);
    assign overflowHit[g] = ret && !consume[g] && atFull;
    assign credit_d[g]    = (ret && !consume[g] && !atFull) ? credit_q[g] + CW'(1) :
                            (!ret && consume[g])            ? credit_q[g] - CW'(1) :
                                                              credit_q[g];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      numWords_q <= '0;
      mask_q     <= '0;
      cur_q      <= '0;
      holdData_q <= '0;
      holdTail_q <= 1'b0;
      flit_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
      credit_q   <= {NUM_MAPPERS{CreditFull}};
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      numWords_q <= numWords_d;
      mask_q     <= mask_d;
      cur_q      <= cur_d;
      holdData_q <= holdData_d;
      holdTail_q <= holdTail_d;
      flit_q     <= flit_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      overflow_q <= overflow_q | (|overflowHit);
      credit_q   <= credit_d;
    end
  end

  assign unusedVcBits      = ^credit_in_i;
  assign sram_rd_en_o      = (state_q == RD);
  assign sram_addr_o       = addr_q;
  assign flit_out_o        = flit_q;
  assign en_get_credit_o   = '1;
  assign busy_o            = busy_q;
  assign done_o            = done_q;
  assign credit_overflow_o = overflow_q;

endmodule

// File: tb/tb_noc_flit_dispatcher.sv
// Scoreboard bench for noc_flit_dispatcher: expected flits are queued when a
// transfer is launched and popped as flits appear on the output.
module tb_noc_flit_dispatcher;

  localparam int AW = 10;
  localparam int FW = 39;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW:0]   numWords;
  logic [3:0]    mask;
  logic          sramRdEn;
  logic [AW-1:0] sramAddr;
  logic [31:0]   sramData = '0;
  logic          sramTail = 1'b0;
  logic [FW-1:0] flitOut;
  logic [7:0]    creditIn;
  logic [3:0]    enGetCredit;
  logic          busy;
  logic          done;
  logic          creditOverflow;

  logic [31:0]   memData [1024];
  logic          memTail [1024];

  logic [FW-1:0] sbQueue [$];
  int            flitCycle [$];
  logic [FW-1:0] monExp;
  int            benchCredit [4];
  int            cycleCnt = 0;
  int            doneCount = 0;
  int            doneCycle = 0;
  int            totalChecks = 0;
  int            badChecks = 0;
  int            c0;
  int            prevDone;

  noc_flit_dispatcher dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .start_i           (start),
    .num_words_i       (numWords),
    .mapper_mask_i     (mask),
    .sram_rd_en_o      (sramRdEn),
    .sram_addr_o       (sramAddr),
    .sram_data_i       (sramData),
    .sram_tail_i       (sramTail),
    .flit_out_o        (flitOut),
    .credit_in_i       (creditIn),
    .en_get_credit_o   (enGetCredit),
    .busy_o            (busy),
    .done_o            (done),
    .credit_overflow_o (creditOverflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  always @(posedge clk) begin
    if (sramRdEn) begin
      sramData <= memData[sramAddr];
      sramTail <= memTail[sramAddr];
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    totalChecks++;
    if (observed !== expected) begin
      badChecks++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Output monitor: every valid flit must match the head of the scoreboard.
  always @(negedge clk) begin
    if (flitOut[FW-1] === 1'b1) begin
      flitCycle.push_back(cycleCnt);
      if (sbQueue.size() == 0) begin
        checkOutput("sbExtraFlit", 64'(flitOut), 64'(0));
      end else begin
        monExp = sbQueue.pop_front();
        checkOutput("sbFlit", 64'(flitOut), 64'(monExp));
        if (monExp[36:33] < 4) benchCredit[monExp[34:33]]--;
      end
    end
    if (done === 1'b1) begin
      doneCount++;
      doneCycle = cycleCnt;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int firstEnabled(input logic [3:0] m);
    for (int i = 0; i < 4; i++) begin
      if (m[2'(i)]) return i;
    end
    return 0;
  endfunction

  function automatic int rrNext(input logic [3:0] m, input int cur);
    logic [1:0] idx;
    for (int step = 1; step <= 4; step++) begin
      idx = 2'((cur + step) % 4);
      if (m[idx]) return int'(idx);
    end
    return cur;
  endfunction

  task automatic applyStimulus(input int n, input logic [3:0] m, input logic [15:0] tails,
                               input logic [31:0] base, output int startCycle);
    int cur;
    cur = firstEnabled(m);
    flitCycle.delete();
    for (int w = 0; w < n; w++) begin
      memData[10'(w)] = base + 32'(w);
      memTail[10'(w)] = tails[4'(w)];
      sbQueue.push_back({1'b1, tails[4'(w)], 4'(cur), 1'b0, base + 32'(w)});
      if (tails[4'(w)]) cur = rrNext(m, cur);
    end
    numWords   = 11'(n);
    mask       = m;
    start      = 1'b1;
    startCycle = cycleCnt;
    tick();
    start      = 1'b0;
  endtask

  task automatic returnCredit(input logic [3:0] m);
    creditIn = '0;
    for (int i = 0; i < 4; i++) begin
      if (m[2'(i)]) begin
        creditIn[2*i+1] = 1'b1;
        benchCredit[i]++;
      end
    end
    tick();
    creditIn = '0;
  endtask

  task automatic refill();
    logic [3:0] need;
    for (int iter = 0; iter < 8; iter++) begin
      need = '0;
      for (int i = 0; i < 4; i++) if (benchCredit[i] < 4) need[2'(i)] = 1'b1;
      if (need != '0) returnCredit(need);
    end
  endtask

  task automatic waitDone(input int prev, input int budget, input string tag);
    int k;
    k = 0;
    while (doneCount == prev && k < budget) begin
      tick();
      k++;
    end
    checkOutput(tag, 64'(doneCount - prev), 64'(1));
  endtask

  task automatic checkCredits(input string tag);
    for (int i = 0; i < 4; i++) begin
      checkOutput(tag, 64'(dut.credit_q[i]), 64'(benchCredit[i]));
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog observed=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    start = 1'b0;
    numWords = '0;
    mask = '0;
    creditIn = '0;
    for (int i = 0; i < 4; i++) benchCredit[i] = 4;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    $display("[TB] reset values");
    checkOutput("rstFlit", 64'(flitOut), 64'(0));
    checkOutput("rstRdEn", 64'(sramRdEn), 64'(0));
    checkOutput("rstAddr", 64'(sramAddr), 64'(0));
    checkOutput("rstBusy", 64'(busy), 64'(0));
    checkOutput("rstDone", 64'(done), 64'(0));
    checkOutput("rstOverflow", 64'(creditOverflow), 64'(0));
    checkOutput("rstEnCredit", 64'(enGetCredit), 64'(4'hF));
    checkCredits("rstCredit");

    $display("[TB] basic transfer");
    prevDone = doneCount;
    applyStimulus(8, 4'hF, 16'h00AA, 32'hA000_0000, c0);
    checkOutput("basicBusy", 64'(busy), 64'(1));
    waitDone(prevDone, 60, "basicDone");
    checkOutput("basicCount", 64'(flitCycle.size()), 64'(8));
    checkOutput("basicLatency", 64'(flitCycle[0] - c0), 64'(4));
    checkOutput("basicDoneGap", 64'(doneCycle - flitCycle[$]), 64'(1));
    checkOutput("basicSbDrain", 64'(sbQueue.size()), 64'(0));
    checkCredits("basicCredit");
    refill();

    $display("[TB] credit stall");
    prevDone = doneCount;
    applyStimulus(6, 4'hF, 16'h0020, 32'hB000_0000, c0);
    repeat (30) tick();
    checkOutput("stallCount", 64'(flitCycle.size()), 64'(4));
    checkOutput("stallBusy", 64'(busy), 64'(1));
    checkOutput("stallCredit0", 64'(dut.credit_q[0]), 64'(0));
    returnCredit(4'b0001);
    returnCredit(4'b0001);
    waitDone(prevDone, 40, "stallDone");
    checkOutput("stallFinalCount", 64'(flitCycle.size()), 64'(6));
    checkOutput("stallFinalCredit0", 64'(dut.credit_q[0]), 64'(0));
    checkOutput("stallSbDrain", 64'(sbQueue.size()), 64'(0));
    refill();

    $display("[TB] mask skip");
    prevDone = doneCount;
    applyStimulus(4, 4'b1010, 16'h000F, 32'hC000_0000, c0);
    waitDone(prevDone, 40, "maskDone");
    checkOutput("maskCount", 64'(flitCycle.size()), 64'(4));
    prevDone = doneCount;
    applyStimulus(3, 4'b0000, 16'h0007, 32'hC100_0000, c0);
    waitDone(prevDone, 40, "maskZeroDone");
    checkOutput("maskSbDrain", 64'(sbQueue.size()), 64'(0));
    checkCredits("maskCredit");
    refill();

    $display("[TB] simultaneous credit events");
    prevDone = doneCount;
    applyStimulus(1, 4'b0001, 16'h0001, 32'hD000_0000, c0);
    tick();
    tick();
    returnCredit(4'b0001);
    waitDone(prevDone, 20, "simulDone");
    checkOutput("simulCredit0", 64'(dut.credit_q[0]), 64'(4));
    checkOutput("simulNoOverflow", 64'(creditOverflow), 64'(0));
    returnCredit(4'b0001);
    benchCredit[0] = 4;
    tick();
    checkOutput("overflowSet", 64'(creditOverflow), 64'(1));
    checkOutput("overflowSaturate", 64'(dut.credit_q[0]), 64'(4));
    prevDone = doneCount;
    applyStimulus(1, 4'b0001, 16'h0001, 32'hD100_0000, c0);
    waitDone(prevDone, 20, "overflowRunDone");
    checkOutput("overflowSticky", 64'(creditOverflow), 64'(1));
    refill();

    $display("[TB] zero-length transfer");
    prevDone = doneCount;
    applyStimulus(0, 4'hF, 16'h0000, 32'h0, c0);
    waitDone(prevDone, 10, "zeroDone");
    checkOutput("zeroDoneLatency", 64'(doneCycle - c0), 64'(2));
    checkOutput("zeroNoFlits", 64'(flitCycle.size()), 64'(0));

    $display("[TB] start while busy");
    prevDone = doneCount;
    applyStimulus(4, 4'hF, 16'h000F, 32'hE000_0000, c0);
    repeat (4) tick();
    numWords = 11'd2;
    mask     = 4'b0010;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    for (int k = 0; k < 40 && cycleCnt < c0 + 13; k++) tick();
    numWords = 11'd5;
    mask     = 4'hF;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    waitDone(prevDone, 30, "busyStartDone");
    repeat (20) tick();
    checkOutput("busyStartCount", 64'(flitCycle.size()), 64'(4));
    checkOutput("busyStartLastFlit", 64'(flitCycle[$] - c0), 64'(13));
    checkOutput("busyStartOneDone", 64'(doneCount - prevDone), 64'(1));
    checkOutput("busyStartIdle", 64'(busy), 64'(0));
    checkOutput("busyStartSbDrain", 64'(sbQueue.size()), 64'(0));

    $display("[TB] last word without tail");
    prevDone = doneCount;
    applyStimulus(3, 4'hF, 16'h0001, 32'hF000_0000, c0);
    waitDone(prevDone, 30, "noTailDone");
    checkOutput("noTailCount", 64'(flitCycle.size()), 64'(3));
    checkOutput("noTailSbDrain", 64'(sbQueue.size()), 64'(0));
    checkCredits("noTailCredit");
    refill();

    $display("[TB] reset mid-transfer");
    applyStimulus(8, 4'hF, 16'h00AA, 32'h1100_0000, c0);
    for (int k = 0; k < 10 && cycleCnt < c0 + 6; k++) tick();
    rst = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) benchCredit[i] = 4;
    sbQueue.delete();
    checkOutput("midRstFlit", 64'(flitOut), 64'(0));
    checkOutput("midRstRdEn", 64'(sramRdEn), 64'(0));
    checkOutput("midRstAddr", 64'(sramAddr), 64'(0));
    checkOutput("midRstBusy", 64'(busy), 64'(0));
    checkOutput("midRstOverflow", 64'(creditOverflow), 64'(0));
    checkCredits("midRstCredit");
    rst = 1'b0;
    prevDone = doneCount;
    repeat (5) tick();
    checkOutput("midRstNoDone", 64'(doneCount - prevDone), 64'(0));
    prevDone = doneCount;
    applyStimulus(4, 4'hF, 16'h000F, 32'h2200_0000, c0);
    waitDone(prevDone, 40, "postRstDone");
    checkOutput("postRstLatency", 64'(flitCycle[0] - c0), 64'(4));
    checkOutput("postRstSbDrain", 64'(sbQueue.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
